// File: rtl/flit_sink_monitor.sv
// Flit sink with packet-length checking and traffic statistics.
// Counts flits, packets, bit toggles and cycles; all outputs registered.
module flit_sink_monitor #(
    parameter int N       = 29,
    parameter int PAYLOAD = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flit_valid,
    input  logic [2*N-1:0] flit_data,
    input  logic           meas_en,
    input  logic           clr,
    output logic           pkt_done,
    output logic           len_err,
    output logic [7:0]     last_len,
    output logic [15:0]    pkt_count,
    output logic [31:0]    flit_count,
    output logic [31:0]    toggle_count,
    output logic [31:0]    busy_cycles,
    output logic [31:0]    total_cycles
);

    localparam logic [7:0] LAST = 8'(PAYLOAD - 1);
    localparam logic [7:0] FULL = 8'(PAYLOAD);

    typedef enum logic {IDLE, RECV} state_e;

    state_e         state_q, state_d;
    logic [7:0]     fcnt_q, fcnt_d;
    logic [2*N-1:0] prev_q;
    logic           done_ev, short_ev;
    logic [31:0]    delta;
    logic [32:0]    tsum;

    logic           pkt_done_q, len_err_q;
    logic [7:0]     last_len_q, last_len_d;
    logic [15:0]    pkt_q;
    logic [31:0]    flit_q, tog_q, busy_q, total_q;

    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (flit_valid) begin
                    state_d = RECV;
                    fcnt_d  = 8'd1;
                end
            end
            RECV: begin
                if (!flit_valid || fcnt_q == LAST) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_ev    = (state_q == RECV) && flit_valid && (fcnt_q == LAST);
        short_ev   = (state_q == RECV) && !flit_valid;
        last_len_d = last_len_q;
        if (done_ev)
            last_len_d = FULL;
        else if (short_ev)
            last_len_d = fcnt_q;
    end

    always_comb begin
        delta = '0;
        for (int i = 0; i < 2 * N; i++)
            delta = delta + 32'(flit_data[i] ^ prev_q[i]);
        tsum = {1'b0, tog_q} + {1'b0, delta};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            pkt_done_q <= 1'b0;
            last_len_q <= '0;
        end else begin
            if (flit_valid)
                prev_q <= flit_data;
            pkt_done_q <= done_ev;
            last_len_q <= last_len_d;
        end
    end

    // clr outranks every same-cycle increment and the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err_q <= 1'b0;
            pkt_q     <= '0;
            flit_q    <= '0;
            tog_q     <= '0;
            busy_q    <= '0;
            total_q   <= '0;
        end else if (clr) begin
            len_err_q <= 1'b0;
            pkt_q     <= '0;
            flit_q    <= '0;
            tog_q     <= '0;
            busy_q    <= '0;
            total_q   <= '0;
        end else begin
            if (short_ev)
                len_err_q <= 1'b1;
            if (meas_en) begin
                total_q <= sat32(total_q);
                if (done_ev)
                    pkt_q <= sat16(pkt_q);
                if (flit_valid) begin
                    flit_q <= sat32(flit_q);
                    busy_q <= sat32(busy_q);
                    tog_q  <= tsum[32] ? '1 : tsum[31:0];
                end
            end
        end
    end

    assign pkt_done     = pkt_done_q;
    assign len_err      = len_err_q;
    assign last_len     = last_len_q;
    assign pkt_count    = pkt_q;
    assign flit_count   = flit_q;
    assign toggle_count = tog_q;
    assign busy_cycles  = busy_q;
    assign total_cycles = total_q;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Bench for flit_sink_monitor: packet scoreboard plus directed
// counter checks for the main traffic scenarios.
module tb_flit_sink_monitor;

    localparam int N  = 29;
    localparam int P  = 20;
    localparam int FW = 2 * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flit_valid;
    logic [FW-1:0] flit_data;
    logic          meas_en;
    logic          clr;
    logic          pkt_done;
    logic          len_err;
    logic [7:0]    last_len;
    logic [15:0]   pkt_count;
    logic [31:0]   flit_count;
    logic [31:0]   toggle_count;
    logic [31:0]   busy_cycles;
    logic [31:0]   total_cycles;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int done_cnt;
    int m_fcnt;
    bit m_recv;
    int sb_q[$];
    int done_hist[$];

    flit_sink_monitor #(.N(N), .PAYLOAD(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flit_valid   (flit_valid),
        .flit_data    (flit_data),
        .meas_en      (meas_en),
        .clr          (clr),
        .pkt_done     (pkt_done),
        .len_err      (len_err),
        .last_len     (last_len),
        .pkt_count    (pkt_count),
        .flit_count   (flit_count),
        .toggle_count (toggle_count),
        .busy_cycles  (busy_cycles),
        .total_cycles (total_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && pkt_done === 1'b1) begin
            done_cnt++;
            done_hist.push_back(cyc_n);
            if (sb_q.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                chk("done_cyc", 64'(cyc_n), 64'(sb_q.pop_front()));
                chk("done_len", 64'(last_len), 64'(P));
            end
        end
    end

    task automatic model_clear();
        m_fcnt   = 0;
        m_recv   = 1'b0;
        done_cnt = 0;
        sb_q.delete();
        done_hist.delete();
    endtask

    task automatic step(input bit v, input logic [FW-1:0] d);
        flit_valid = v;
        flit_data  = d;
        if (v) begin
            if (!m_recv) begin
                m_recv = 1'b1;
                m_fcnt = 1;
            end else if (m_fcnt == P - 1) begin
                sb_q.push_back(cyc_n + 1);
                m_recv = 1'b0;
                m_fcnt = 0;
            end else begin
                m_fcnt++;
            end
        end else begin
            m_recv = 1'b0;
            m_fcnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] rnd();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        flit_valid = 1'b0;
        flit_data  = '0;
        meas_en    = 1'b0;
        clr        = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_cnt", {pkt_count, flit_count[15:0], toggle_count[15:0],
                        total_cycles[15:0]}, 64'd0);
        chk("rst_flag", {busy_cycles, last_len, 6'd0, len_err, pkt_done},
            64'd0);
        rst_n = 1'b1;
    endtask

    logic [FW-1:0] ones;
    logic [FW-1:0] pat;

    initial begin
        ones = '1;
        pat  = {18'h3FFFF, 40'h0};
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // toggles: zero, all-ones, top-18-bit pattern
        do_reset();
        meas_en = 1'b1;
        step(1'b1, '0);
        chk("tog_zero", 64'(toggle_count), 64'd0);
        step(1'b1, ones);
        chk("tog_ones", 64'(toggle_count), 64'd58);
        step(1'b1, pat);
        chk("tog_pat", 64'(toggle_count), 64'd98);
        step(1'b0, '0);
        chk("tog_lerr", 64'(len_err), 64'd1);
        chk("tog_llen", 64'(last_len), 64'd3);
        chk("tog_flits", 64'(flit_count), 64'd3);

        // short packet
        do_reset();
        meas_en = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, rnd());
        step(1'b0, '0);
        chk("sh_lerr", 64'(len_err), 64'd1);
        chk("sh_llen", 64'(last_len), 64'd5);
        chk("sh_pkts", 64'(pkt_count), 64'd0);
        chk("sh_done", 64'(done_cnt), 64'd0);

        // ten packets with 7-cycle gaps, 270 measured cycles
        do_reset();
        meas_en = 1'b1;
        for (int p = 0; p < 10; p++) begin
            for (int f = 0; f < P; f++) step(1'b1, rnd());
            for (int g = 0; g < 7; g++) step(1'b0, '0);
        end
        meas_en = 1'b0;
        chk("ten_pkts", 64'(pkt_count), 64'd10);
        chk("ten_flits", 64'(flit_count), 64'd200);
        chk("ten_busy", 64'(busy_cycles), 64'd200);
        chk("ten_total", 64'(total_cycles), 64'd270);
        chk("ten_lerr", 64'(len_err), 64'd0);
        chk("ten_done", 64'(done_cnt), 64'd10);
        for (int f = 0; f < P; f++) step(1'b1, rnd());
        step(1'b0, '0);
        chk("hold_pkts", 64'(pkt_count), 64'd10);
        chk("hold_flits", 64'(flit_count), 64'd200);
        chk("hold_total", 64'(total_cycles), 64'd270);
        chk("hold_done", 64'(done_cnt), 64'd11);

        // back-to-back packets
        do_reset();
        meas_en = 1'b1;
        for (int f = 0; f < 2 * P; f++) step(1'b1, rnd());
        step(1'b0, '0);
        chk("b2b_pkts", 64'(pkt_count), 64'd2);
        chk("b2b_done", 64'(done_cnt), 64'd2);
        if (done_hist.size() == 2)
            chk("b2b_gap", 64'(done_hist[1] - done_hist[0]), 64'd20);
        else
            chk("b2b_hist", 64'(done_hist.size()), 64'd2);
        chk("b2b_lerr", 64'(len_err), 64'd0);

        // reset in the middle of a packet
        do_reset();
        meas_en = 1'b1;
        for (int f = 0; f < 11; f++) step(1'b1, rnd());
        flit_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_flits", 64'(flit_count), 64'd0);
        chk("async_pcnt", 64'(pkt_count), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int f = 0; f < P; f++) step(1'b1, rnd());
        step(1'b0, '0);
        chk("mid_pkts", 64'(pkt_count), 64'd1);
        chk("mid_lerr", 64'(len_err), 64'd0);
        chk("mid_done", 64'(done_cnt), 64'd1);

        // clr on the final flit
        do_reset();
        meas_en = 1'b1;
        for (int f = 0; f < P - 1; f++) step(1'b1, rnd());
        clr = 1'b1;
        step(1'b1, rnd());
        clr = 1'b0;
        chk("clr_done", 64'(pkt_done), 64'd1);
        chk("clr_pkts", 64'(pkt_count), 64'd0);
        chk("clr_flits", 64'(flit_count), 64'd0);
        chk("clr_tog", 64'(toggle_count), 64'd0);
        chk("clr_busy", 64'(busy_cycles), 64'd0);
        chk("clr_total", 64'(total_cycles), 64'd0);
        chk("clr_llen", 64'(last_len), 64'd20);
        step(1'b0, '0);
        chk("sb_left", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
